// File: rtl/traffic_queue_sensor.sv
// Per-street vehicle queue counters plus a light-protocol monitor that
// latches the first conflict, illegal-code or sequencing violation it sees.
module traffic_queue_sensor #(
   parameter int QW         = 4,
   parameter int MIN_YELLOW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    La,
   input  logic [1:0]    Lb,
   input  logic          arr_a,
   input  logic          arr_b,
   output logic          Ta,
   output logic          Tb,
   output logic [QW-1:0] qa,
   output logic [QW-1:0] qb,
   output logic          ovf,
   output logic          fault,
   output logic [1:0]    fault_code
);

   localparam int            YW    = (MIN_YELLOW < 1) ? 1 : $clog2(MIN_YELLOW + 1);
   localparam logic [YW-1:0] Y_SAT = YW'(MIN_YELLOW);
   localparam logic [QW-1:0] Q_MAX = '1;

   typedef enum logic [1:0] {
      RED     = 2'b00,
      YELLOW  = 2'b01,
      GREEN   = 2'b10,
      ILLEGAL = 2'b11
   } light_t;

   typedef enum logic [1:0] {
      F_NONE     = 2'b00,
      F_CONFLICT = 2'b01,
      F_ILLEGAL  = 2'b10,
      F_SEQUENCE = 2'b11
   } fault_t;

   logic [1:0]    pLa, pLb;
   logic [YW-1:0] ya, yb;
   logic [QW-1:0] qa_nxt, qb_nxt;
   logic          dep_a, dep_b, sat_a, sat_b;
   fault_t        viol;

   function automatic logic seq_bad(input logic [1:0] prev, input logic [1:0] cur,
                                    input logic [YW-1:0] run);
      logic bad;
      bad = 1'b0;
      // Illegal codes are reported on their own and never feed the sequence check.
      if (prev != ILLEGAL && cur != ILLEGAL) begin
         case ({prev, cur})
            {GREEN,  RED}:    bad = 1'b1;
            {RED,    YELLOW}: bad = 1'b1;
            {YELLOW, GREEN}:  bad = 1'b1;
            {YELLOW, RED}:    bad = (run < Y_SAT);
            default:          bad = 1'b0;
         endcase
      end
      return bad;
   endfunction

   function automatic logic [QW-1:0] q_step(input logic [QW-1:0] q, input logic arr,
                                            input logic dep);
      logic [QW-1:0] r;
      r = q;
      if (arr && !dep && q != Q_MAX) r = q + QW'(1);
      else if (dep && !arr)          r = q - QW'(1);
      return r;
   endfunction

   function automatic logic [YW-1:0] y_step(input logic [1:0] cur, input logic [YW-1:0] run);
      logic [YW-1:0] r;
      r = '0;
      if (cur == YELLOW) r = (run == Y_SAT) ? run : run + YW'(1);
      return r;
   endfunction

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      viol   = F_NONE;
      dep_a  = (La == GREEN) && (qa != '0);
      dep_b  = (Lb == GREEN) && (qb != '0);
      sat_a  = arr_a && !dep_a && (qa == Q_MAX);
      sat_b  = arr_b && !dep_b && (qb == Q_MAX);
      qa_nxt = q_step(qa, arr_a, dep_a);
      qb_nxt = q_step(qb, arr_b, dep_b);
      if (La == ILLEGAL || Lb == ILLEGAL)
         viol = F_ILLEGAL;
      else if (La != RED && Lb != RED)
         viol = F_CONFLICT;
      else if (seq_bad(pLa, La, ya) || seq_bad(pLb, Lb, yb))
         viol = F_SEQUENCE;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         qa         <= '0;
         qb         <= '0;
         ovf        <= 1'b0;
         fault      <= 1'b0;
         fault_code <= F_NONE;
         pLa        <= GREEN;
         pLb        <= RED;
         ya         <= '0;
         yb         <= '0;
      end else begin
         qa  <= qa_nxt;
         qb  <= qb_nxt;
         pLa <= La;
         pLb <= Lb;
         ya  <= y_step(La, ya);
         yb  <= y_step(Lb, yb);
         if (sat_a || sat_b) ovf <= 1'b1;
         // Only the first violation is recorded; fault_code is frozen afterwards.
         if (!fault && viol != F_NONE) begin
            fault      <= 1'b1;
            fault_code <= viol;
         end
      end
   end

   assign Ta = (qa != '0);
   assign Tb = (qb != '0);

endmodule

// File: tb/tb_traffic_queue_sensor.sv
// Scoreboard bench: driver pushes model predictions per cycle, a monitor pops
// and compares one prediction after every rising edge.
module tb_traffic_queue_sensor;

   localparam int QW         = 4;
   localparam int MIN_YELLOW = 2;
   localparam int QMAX       = (1 << QW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    La = 2'b10, Lb = 2'b00;
   logic          arr_a = 1'b0, arr_b = 1'b0;
   logic          Ta, Tb, ovf, fault;
   logic [QW-1:0] qa, qb;
   logic [1:0]    fault_code;

   traffic_queue_sensor #(.QW(QW), .MIN_YELLOW(MIN_YELLOW)) dut (
      .clk(clk), .reset(reset), .La(La), .Lb(Lb), .arr_a(arr_a), .arr_b(arr_b),
      .Ta(Ta), .Tb(Tb), .qa(qa), .qb(qb), .ovf(ovf), .fault(fault),
      .fault_code(fault_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      int qa;
      int qb;
      int ovf;
      int fault;
      int code;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model state (plain integers, light codes as 0..3).
   int m_qa, m_qb, m_ovf, m_fault, m_code, m_pa, m_pb, m_ya, m_yb;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int bad_move(input int p, input int c, input int run);
      if (p == 3 || c == 3 || p == c) return 0;
      if (p == 0 && c == 2) return 0;
      if (p == 2 && c == 1) return 0;
      if (p == 1 && c == 0 && run >= MIN_YELLOW) return 0;
      return 1;
   endfunction

   task automatic model_reset();
      m_qa = 0; m_qb = 0; m_ovf = 0; m_fault = 0; m_code = 0;
      m_pa = 2; m_pb = 0; m_ya = 0; m_yb = 0;
   endtask

   task automatic model_step(input int la, input int lb, input int aa, input int ab);
      int v, na, nb;
      if (la == 3 || lb == 3)                                           v = 2;
      else if (la != 0 && lb != 0)                                      v = 1;
      else if (bad_move(m_pa, la, m_ya) || bad_move(m_pb, lb, m_yb))    v = 3;
      else                                                              v = 0;
      if (m_fault == 0 && v != 0) begin
         m_fault = 1;
         m_code  = v;
      end
      na = m_qa + aa - ((la == 2 && m_qa > 0) ? 1 : 0);
      nb = m_qb + ab - ((lb == 2 && m_qb > 0) ? 1 : 0);
      if (na > QMAX) begin na = QMAX; m_ovf = 1; end
      if (nb > QMAX) begin nb = QMAX; m_ovf = 1; end
      m_qa = na;
      m_qb = nb;
      m_ya = (la == 1) ? m_ya + 1 : 0;
      m_yb = (lb == 1) ? m_yb + 1 : 0;
      m_pa = la;
      m_pb = lb;
   endtask

   task automatic push_exp();
      exp_t e;
      e.qa = m_qa; e.qb = m_qb; e.ovf = m_ovf; e.fault = m_fault; e.code = m_code;
      sb.push_back(e);
   endtask

   task automatic cyc(input int la, input int lb, input int aa, input int ab);
      @(negedge clk);
      reset = 1'b0;
      La    = 2'(la);
      Lb    = 2'(lb);
      arr_a = 1'(aa);
      arr_b = 1'(ab);
      model_step(la, lb, aa, ab);
      push_exp();
   endtask

   // Reset is raised between edges; outputs must clear before any clock edge.
   task automatic rst_cyc();
      @(negedge clk);
      reset = 1'b1;
      La = 2'b10; Lb = 2'b00; arr_a = 1'b0; arr_b = 1'b0;
      model_reset();
      #1;
      check("async_qa", int'(qa), 0);
      check("async_ta", int'(Ta), 0);
      check("async_fault", int'(fault), 0);
      check("async_code", int'(fault_code), 0);
      push_exp();
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("qa", int'(qa), e.qa);
            check("qb", int'(qb), e.qb);
            check("Ta", int'(Ta), (e.qa != 0) ? 1 : 0);
            check("Tb", int'(Tb), (e.qb != 0) ? 1 : 0);
            check("ovf", int'(ovf), e.ovf);
            check("fault", int'(fault), e.fault);
            check("fault_code", int'(fault_code), e.code);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      int phase, hold, la, lb;
      model_reset();
      #12;

      // Queue fill with red, then drain with green.
      rst_cyc();
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
      after_edge();
      check("fill_qa", int'(qa), 3);
      check("fill_Ta", int'(Ta), 1);
      for (int i = 0; i < 3; i++) cyc(2, 0, 0, 0);
      after_edge();
      check("drain_qa", int'(qa), 0);
      check("drain_Ta", int'(Ta), 0);

      // Saturation on street B, then simultaneous arrival and departure.
      rst_cyc();
      for (int i = 0; i < 16; i++) cyc(2, 0, 0, 1);
      after_edge();
      check("sat_qb", int'(qb), 15);
      check("sat_ovf", int'(ovf), 1);
      cyc(0, 2, 0, 1);
      after_edge();
      check("sat_hold_qb", int'(qb), 15);

      // Fully legal cycle on both streets.
      rst_cyc();
      cyc(2, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
      cyc(0, 2, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
      after_edge();
      check("legal_fault", int'(fault), 0);

      // Short yellow.
      rst_cyc();
      cyc(2, 0, 0, 0); cyc(1, 0, 0, 0);
      after_edge();
      check("short_y_pre", int'(fault), 0);
      cyc(0, 0, 0, 0);
      after_edge();
      check("short_y_fault", int'(fault), 1);
      check("short_y_code", int'(fault_code), 3);

      // Conflict first, later illegal code must not overwrite it.
      rst_cyc();
      cyc(2, 2, 0, 0); cyc(3, 0, 0, 0);
      after_edge();
      check("first_code", int'(fault_code), 1);

      // Mid-operation async reset with qa=5 and fault set.
      rst_cyc();
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
      after_edge();
      check("pre_rst_qa", int'(qa), 5);
      check("pre_rst_fault", int'(fault), 1);
      rst_cyc();

      // Randomized: alternate legal-controller segments and free-running lights.
      phase = 0;
      hold  = 2;
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 0) begin
            rst_cyc();
            phase = 0;
            hold  = int'($urandom_range(1, 3));
         end
         if ((i / 50) % 2 == 0) begin
            case (phase)
               0: begin la = 2; lb = 0; end
               1: begin la = 1; lb = 0; end
               3: begin la = 0; lb = 2; end
               4: begin la = 0; lb = 1; end
               default: begin la = 0; lb = 0; end
            endcase
            hold--;
            if (hold == 0) begin
               phase = (phase + 1) % 6;
               hold = (phase == 1 || phase == 4) ? int'($urandom_range(MIN_YELLOW, MIN_YELLOW + 2))
                                                 : int'($urandom_range(1, 3));
            end
         end else begin
            la = int'($urandom_range(0, 3));
            lb = int'($urandom_range(0, 3));
         end
         cyc(la, lb, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      end

      after_edge();
      after_edge();
      check("sb_drain", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/traffic_queue_sensor.md
TRAFFIC_QUEUE_SENSOR -- requirements
Module: traffic_queue_sensor

Interface
REQ-001 SHALL have parameter QW, default 4, the width of each street's vehicle-queue counter.
REQ-002 SHALL have parameter MIN_YELLOW, default 2, the minimum number of consecutive yellow cycles before red.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port La  input  2  street A light code: 00 red, 01 yellow, 10 green, 11 illegal.
REQ-006 SHALL have port Lb  input  2  street B light code, same encoding as La.
REQ-007 SHALL have port arr_a  input  1  one-cycle vehicle-arrival pulse, street A.
REQ-008 SHALL have port arr_b  input  1  one-cycle vehicle-arrival pulse, street B.
REQ-009 SHALL have port Ta  output  1  street A traffic present, i.e. qa != 0.
REQ-010 SHALL have port Tb  output  1  street B traffic present, i.e. qb != 0.
REQ-011 SHALL have port qa  output  QW  street A queue count, registered.
REQ-012 SHALL have port qb  output  QW  street B queue count, registered.
REQ-013 SHALL have port ovf  output  1  sticky flag: an arrival was dropped at saturation on either street.
REQ-014 SHALL have port fault  output  1  sticky flag: a light-protocol violation was detected.
REQ-015 SHALL have port fault_code  output  2  first violation: 00 none, 01 conflict, 10 illegal code, 11 sequence error.

Function
REQ-016 SHALL update the queue per street at each posedge: +1 on arrival only; -1 on departure only; unchanged when both or neither occur.
REQ-017 SHALL count a departure on street A only when La==10 and qa>0 at the sampling edge; street B likewise with Lb and qb.
REQ-018 SHALL hold the count at 2^QW-1 on an arrival without a departure, and SHALL set ovf in that case.
REQ-019 SHALL never decrement below 0; green with an empty queue leaves the count at 0.
REQ-020 SHALL drive Ta and Tb combinationally from the registered qa and qb, so an arrival at edge k raises Ta after edge k with no added latency.
REQ-021 SHALL register La and Lb each cycle as pLa and pLb, and keep per-street yellow-run counters (ya, yb) that saturate at MIN_YELLOW.
REQ-022 SHALL flag illegal code (10) whenever La==11 or Lb==11.
REQ-023 SHALL flag conflict (01) whenever La!=00 and Lb!=00 in the same cycle.
REQ-024 SHALL flag sequence error (11) on any of these per-street transitions:
  - green->red
  - red->yellow
  - yellow->green
  - yellow->red with yellow run < MIN_YELLOW
REQ-025 SHALL allow exactly these per-street transitions: red->green, green->yellow, yellow->red (run >= MIN_YELLOW), and hold in the same code.
REQ-026 SHALL resolve simultaneous violations in a cycle by priority: illegal code > conflict > sequence.
REQ-027 SHALL assert fault at the edge after the violating inputs are sampled.
REQ-028 SHALL latch fault_code from the first violation only; later violations SHALL NOT change it.
REQ-029 SHALL exclude illegal codes from the sequence check in the cycle after an illegal code is sampled.
REQ-030 SHALL leave queue counting unaffected by fault; counting continues normally.

Reset
REQ-031 SHALL, on reset assertion, asynchronously set:
  - qa, qb = 0, hence Ta, Tb = 0
  - ovf, fault = 0; fault_code = 00
  - pLa = 10, pLb = 00; ya, yb = 0
REQ-032 SHALL make the first post-reset cycle with La=10, Lb=00 violation-free.
REQ-033 SHALL honour a reset asserted mid-operation immediately, without waiting for clk; state resumes from the reset values on the first edge after release.

Verification
REQ-034 SHALL verify: reset, then 3 arr_a pulses with La=00 -> qa=3 and Ta=1; then La=10 for 3 cycles -> qa=0 and Ta=0.
REQ-035 SHALL verify: QW=4, 16 arr_b pulses with Lb=00 -> qb=15 and ovf=1; then arr_b together with Lb=10 -> qb=15 unchanged.
REQ-036 SHALL verify: La sequence 10,01,01,00 with Lb=00, then Lb 10,01,01,00 -> fault=0 throughout.
REQ-037 SHALL verify: La 10->01->00 with a single yellow cycle -> fault=1 and fault_code=11 one edge later.
REQ-038 SHALL verify: La=10 and Lb=10 in one cycle, then La=11 -> fault_code=01, unchanged by the later illegal code.
REQ-039 SHALL verify: reset asserted between clock edges while qa=5 and fault=1 -> qa=0, fault=0 and fault_code=00 immediately.
